// File: rtl/securepuf_eval_sched_if.sv
// Requester, response and PUF-core signals of the securePUF evaluation scheduler.
// The scheduler uses the slave modport; the requesters/core side uses master.
interface securepuf_eval_sched_if #(
  parameter int CHAL_W = 64,
  parameter int RESP_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CHAL_W-1:0] req0_chal;
  logic              req1_valid;
  logic              req1_ready;
  logic [CHAL_W-1:0] req1_chal;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RESP_W-1:0] rsp_data;
  logic              rsp_err;
  logic [CHAL_W-1:0] puf_chal;
  logic              puf_start;
  logic              puf_done;
  logic [RESP_W-1:0] puf_resp;
  logic              busy;

  modport slave (
    input  req0_valid, req0_chal, req1_valid, req1_chal, rsp_ready, puf_done, puf_resp,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, puf_chal, puf_start, busy
  );

  modport master (
    output req0_valid, req0_chal, req1_valid, req1_chal, rsp_ready, puf_done, puf_resp,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, puf_chal, puf_start, busy
  );
endinterface

// File: rtl/securepuf_eval_sched.sv
// Round-robin scheduler for one securePUF core: accept -> SETTLE_CYC settle -> start -> wait done/timeout -> respond.
// Start fires SETTLE_CYC cycles after accept; response stalls in RESP until rsp_ready, blocking both requesters.
module securepuf_eval_sched #(
  parameter int CHAL_W      = 64,
  parameter int RESP_W      = 32,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  securepuf_eval_sched_if.slave bus
);
  localparam int MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EVAL, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rr_ptr;
  logic              r_rsp_id;
  logic              r_rsp_err;
  logic [CHAL_W-1:0] r_puf_chal;
  logic [RESP_W-1:0] r_rsp_data;
  logic              w_grant;
  logic              w_accept;
  logic              w_settle_done;
  logic              w_eval_timeout;
  logic              w_rsp_hs;

  // Grant is 1 only when req1 is the sole requester or the pointer favours it.
  assign w_grant        = bus.req1_valid & (~bus.req0_valid | r_rr_ptr);
  assign w_accept       = (r_state == S_IDLE) & ~ARESET & (bus.req0_valid | bus.req1_valid);
  assign w_settle_done  = (r_state == S_SETTLE) & (r_cnt == SETTLE_LAST);
  assign w_eval_timeout = (r_cnt == EVAL_LAST);
  assign w_rsp_hs       = (r_state == S_RESP) & bus.rsp_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nxt = S_EVAL;
      S_EVAL:   if (bus.puf_done || w_eval_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.puf_start  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = w_accept & ~w_grant;
        bus.req1_ready = w_accept & w_grant;
      end
      S_SETTLE: bus.puf_start = w_settle_done;
      S_RESP:   bus.rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt      <= '0;
      r_rr_ptr   <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_puf_chal <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_puf_chal <= w_grant ? bus.req1_chal : bus.req0_chal;
            r_rsp_id   <= w_grant;
          end
        end
        S_SETTLE: r_cnt <= w_settle_done ? '0 : r_cnt + CNT_W'(1);
        S_EVAL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A done arriving on the timeout cycle still yields a valid response.
          if (bus.puf_done) begin
            r_rsp_data <= bus.puf_resp;
            r_rsp_err  <= 1'b0;
          end else if (w_eval_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rr_ptr   <= ~r_rsp_id;
            r_rsp_data <= '0;
            r_puf_chal <= '0;
            r_rsp_err  <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.puf_chal = r_puf_chal;
  assign bus.rsp_id   = r_rsp_id;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;
endmodule

// File: tb/tb_securepuf_eval_sched.sv
// Directed scoreboard bench for securepuf_eval_sched; the PUF core is emulated inline.
// Inputs change 1 time unit after the rising edge, outputs are sampled there or later.
module tb_securepuf_eval_sched;
  localparam int CHAL_W = 64;
  localparam int RESP_W = 32;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  securepuf_eval_sched_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) ifc ();

  securepuf_eval_sched #(
    .CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYC(4), .TIMEOUT_CYC(255)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (ifc.slave)
  );

  typedef struct packed {
    logic              id;
    logic [RESP_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic accept(input logic id, input logic [CHAL_W-1:0] chal);
    int n;
    n = 0;
    if (id) begin ifc.req1_valid = 1'b1; ifc.req1_chal = chal; end
    else    begin ifc.req0_valid = 1'b1; ifc.req0_chal = chal; end
    #1;
    while (!(id ? ifc.req1_ready : ifc.req0_ready) && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk("accept_ready_seen", 64'(n < 20), 64'd1);
    cyc();
    if (id) ifc.req1_valid = 1'b0;
    else    ifc.req0_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!ifc.puf_start && n < 50) begin
      cyc();
      n++;
    end
  endtask

  task automatic core_done(input int d, input logic [RESP_W-1:0] r);
    repeat (d) cyc();
    ifc.puf_done = 1'b1;
    ifc.puf_resp = r;
    cyc();
    ifc.puf_done = 1'b0;
    ifc.puf_resp = '0;
  endtask

  task automatic get_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    e = '0;
    ifc.rsp_ready = 1'b1;
    while (!ifc.rsp_valid && n < 400) begin
      cyc();
      n++;
    end
    chk({tag, "_rsp_seen"}, 64'(n < 400), 64'd1);
    chk({tag, "_queue"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_id"},   64'(ifc.rsp_id),   64'(e.id));
    chk({tag, "_data"}, 64'(ifc.rsp_data), 64'(e.data));
    chk({tag, "_err"},  64'(ifc.rsp_err),  64'(e.err));
    cyc();
    ifc.rsp_ready = 1'b0;
    chk({tag, "_busy_after"},  64'(ifc.busy),      64'd0);
    chk({tag, "_valid_after"}, 64'(ifc.rsp_valid), 64'd0);
    chk({tag, "_data_clr"},    64'(ifc.rsp_data),  64'd0);
    chk({tag, "_chal_clr"},    64'(ifc.puf_chal),  64'd0);
    chk({tag, "_err_clr"},     64'(ifc.rsp_err),   64'd0);
  endtask

  initial begin
    int   n;
    logic exp_id;
    logic [CHAL_W-1:0] chals [2];
    logic [RESP_W-1:0] rr_resp [3];
    logic rr_ids [3];

    chals   = '{64'hAAAA_0000_1111_2222, 64'hBBBB_3333_4444_5555};
    rr_resp = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003};
    rr_ids  = '{1'b0, 1'b1, 1'b0};

    ifc.req0_valid = 1'b0; ifc.req0_chal = '0;
    ifc.req1_valid = 1'b0; ifc.req1_chal = '0;
    ifc.rsp_ready  = 1'b0; ifc.puf_done  = 1'b0; ifc.puf_resp = '0;

    // Reset state
    ARESET = 1'b1;
    repeat (2) cyc();
    chk("rst_busy",      64'(ifc.busy),       64'd0);
    chk("rst_rsp_valid", 64'(ifc.rsp_valid),  64'd0);
    chk("rst_puf_start", 64'(ifc.puf_start),  64'd0);
    chk("rst_puf_chal",  64'(ifc.puf_chal),   64'd0);
    chk("rst_rsp_data",  64'(ifc.rsp_data),   64'd0);
    chk("rst_rsp_err",   64'(ifc.rsp_err),    64'd0);
    chk("rst_req0_rdy",  64'(ifc.req0_ready), 64'd0);
    chk("rst_req1_rdy",  64'(ifc.req1_ready), 64'd0);
    ARESET = 1'b0;
    cyc();

    // Both requesters valid: order 0, 1, 0
    ifc.req0_chal = chals[0]; ifc.req1_chal = chals[1];
    ifc.req0_valid = 1'b1;    ifc.req1_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      exp_id = rr_ids[r];
      #1;
      chk("rr_req0_rdy", 64'(ifc.req0_ready), 64'(exp_id == 1'b0));
      chk("rr_req1_rdy", 64'(ifc.req1_ready), 64'(exp_id == 1'b1));
      exp_q.push_back('{exp_id, rr_resp[r], 1'b0});
      cyc();
      chk("rr_puf_chal", 64'(ifc.puf_chal), 64'(chals[exp_id]));
      wait_start(n);
      chk("rr_start_lat", 64'(n), 64'd4);
      core_done(2, rr_resp[r]);
      get_rsp("rr");
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    cyc();

    // Basic transaction, done 3 cycles after start
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
    accept(1'b0, 64'h0123_4567_89AB_CDEF);
    chk("t1_busy",     64'(ifc.busy),     64'd1);
    chk("t1_puf_chal", 64'(ifc.puf_chal), 64'h0123_4567_89AB_CDEF);
    wait_start(n);
    chk("t1_start_lat", 64'(n), 64'd4);
    cyc();
    chk("t1_start_pulse", 64'(ifc.puf_start), 64'd0);
    core_done(2, 32'hDEAD_BEEF);
    chk("t1_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    get_rsp("t1");

    // Timeout: core never answers
    exp_q.push_back('{1'b0, 32'h0, 1'b1});
    accept(1'b0, 64'h5555_6666_7777_8888);
    wait_start(n);
    chk("t3_start_lat", 64'(n), 64'd4);
    cyc();
    n = 0;
    while (!ifc.rsp_valid && n < 400) begin
      cyc();
      n++;
    end
    chk("t3_timeout_lat", 64'(n), 64'd255);
    get_rsp("t3");
    exp_q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0});
    accept(1'b1, 64'h9999_AAAA_BBBB_CCCC);
    wait_start(n);
    chk("t3b_start_lat", 64'(n), 64'd4);
    core_done(3, 32'hCAFE_F00D);
    get_rsp("t3b");

    // Response backpressure for 10 cycles
    exp_q.push_back('{1'b1, 32'h1234_ABCD, 1'b0});
    accept(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_start(n);
    core_done(2, 32'h1234_ABCD);
    ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_valid",    64'(ifc.rsp_valid),  64'd1);
      chk("t4_id",       64'(ifc.rsp_id),     64'd1);
      chk("t4_data",     64'(ifc.rsp_data),   64'h1234_ABCD);
      chk("t4_req0_rdy", 64'(ifc.req0_ready), 64'd0);
      chk("t4_req1_rdy", 64'(ifc.req1_ready), 64'd0);
      chk("t4_busy",     64'(ifc.busy),       64'd1);
      cyc();
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    get_rsp("t4");

    // Reset during EVAL, then a late done
    accept(1'b0, 64'hFEED_FACE_0BAD_F00D);
    wait_start(n);
    cyc();
    chk("t5_in_eval_busy", 64'(ifc.busy), 64'd1);
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    chk("t5_busy",      64'(ifc.busy),      64'd0);
    chk("t5_puf_start", 64'(ifc.puf_start), 64'd0);
    chk("t5_puf_chal",  64'(ifc.puf_chal),  64'd0);
    ifc.puf_done = 1'b1; ifc.puf_resp = 32'h1234_5678;
    cyc();
    ifc.puf_done = 1'b0; ifc.puf_resp = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
      chk("t5_rsp_data",  64'(ifc.rsp_data),  64'd0);
      chk("t5_rsp_err",   64'(ifc.rsp_err),   64'd0);
      chk("t5_idle",      64'(ifc.busy),      64'd0);
      cyc();
    end

    // Stray done pulses in IDLE and SETTLE
    ifc.puf_done = 1'b1; ifc.puf_resp = 32'hBAD0_BAD0;
    cyc();
    ifc.puf_done = 1'b0; ifc.puf_resp = '0;
    chk("t6_idle_busy",  64'(ifc.busy),      64'd0);
    chk("t6_idle_valid", 64'(ifc.rsp_valid), 64'd0);
    exp_q.push_back('{1'b0, 32'h600D_F00D, 1'b0});
    accept(1'b0, 64'h1357_9BDF_2468_ACE0);
    ifc.puf_done = 1'b1; ifc.puf_resp = 32'hBAD1_BAD1;
    cyc();
    ifc.puf_done = 1'b0; ifc.puf_resp = '0;
    chk("t6_settle_busy", 64'(ifc.busy), 64'd1);
    wait_start(n);
    chk("t6_start_lat", 64'(n), 64'd3);
    chk("t6_puf_chal",  64'(ifc.puf_chal), 64'h1357_9BDF_2468_ACE0);
    core_done(1, 32'h600D_F00D);
    get_rsp("t6");

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
